// File: rtl/top_soc_pkg.sv
// Shared address map, register offsets and accelerator state encoding.
package top_soc_pkg;

    localparam logic [15:0] MEM_BASE = 16'h0000;  // 0x0000-0x07FF, 256 x 64-bit words
    localparam logic [15:0] REG_BASE = 16'h7000;  // 0x7000-0x70FF, accelerator registers

    // Register word indices (byte offset = index * 8), decoded from m_addr[7:3]
    localparam logic [4:0] REG_OPSTART  = 5'h00;
    localparam logic [4:0] REG_OPCLEAR  = 5'h01;
    localparam logic [4:0] REG_OPDONE   = 5'h02;
    localparam logic [4:0] REG_INTR_EN  = 5'h03;
    localparam logic [4:0] REG_OPERAND  = 5'h04;
    localparam logic [4:0] REG_RESULT_H = 5'h05;
    localparam logic [4:0] REG_RESULT_L = 5'h06;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fact_state_e;

endpackage

// File: rtl/top_soc_fact_core.sv
// Factorial accelerator: register file, IDLE/RUN/DONE FSM and multiplier.
// Config macro TOP_FAST_MUL_EN: one-cycle 128x64 multiply per step when
// defined; otherwise a 1 load + MUL_W cycle shift-add step.
module fact_core
    import top_soc_pkg::*;
#(
    parameter int unsigned MUL_W = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_i,
    input  logic [4:0]       idx_i,
    input  logic [MUL_W-1:0] wdata_i,
    output logic [MUL_W-1:0] rdata_o,
    output logic             irq_o
);

    localparam int unsigned RES_W = 2 * MUL_W;

    fact_state_e      state_q, state_d;
    logic [RES_W-1:0] result_q, result_d;
    logic [MUL_W-1:0] mult_q, mult_d;
    logic [MUL_W-1:0] operand_q;
    logic             intr_en_q;
    logic             clr_q;
    logic             clr_eff;
    logic             start_wr;
    logic             busy, done;

`ifndef TOP_FAST_MUL_EN
    localparam int unsigned CNT_W = $clog2(MUL_W + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RES_W-1:0] a_q, a_d;
    logic [RES_W-1:0] acc_q, acc_d;
    logic [MUL_W-1:0] b_q, b_d;
    logic [RES_W-1:0] sum;
`endif

    // The clear level takes effect in the same cycle it is written and holds while bit0 stays 1
    assign clr_eff  = (wr_i && idx_i == REG_OPCLEAR) ? wdata_i[0] : clr_q;
    assign start_wr = wr_i && (idx_i == REG_OPSTART) && wdata_i[0];
    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign irq_o    = intr_en_q & done;

    // Software-writable control registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            operand_q <= '0;
            intr_en_q <= 1'b0;
            clr_q     <= 1'b0;
        end else begin
            clr_q <= clr_eff;
            if (wr_i && idx_i == REG_OPERAND) operand_q <= wdata_i;
            if (wr_i && idx_i == REG_INTR_EN) intr_en_q <= wdata_i[0];
        end
    end

    // FSM state, result/multiplier registers and multiplier datapath
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            result_q <= '0;
            mult_q   <= '0;
`ifndef TOP_FAST_MUL_EN
            cnt_q    <= '0;
            a_q      <= '0;
            acc_q    <= '0;
            b_q      <= '0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            mult_q   <= mult_d;
`ifndef TOP_FAST_MUL_EN
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
`endif
        end
    end

    // Next-state logic: clear dominates start; each RUN step multiplies then decrements mult
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        mult_d   = mult_q;
`ifndef TOP_FAST_MUL_EN
        cnt_d    = cnt_q;
        a_d      = a_q;
        acc_d    = acc_q;
        b_d      = b_q;
        sum      = b_q[0] ? (acc_q + a_q) : acc_q;
`endif
        if (clr_eff) begin
            state_d  = IDLE;
            result_d = '0;
`ifndef TOP_FAST_MUL_EN
            cnt_d    = '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_wr) begin
                        state_d  = RUN;
                        result_d = RES_W'(1);
                        mult_d   = operand_q;
`ifndef TOP_FAST_MUL_EN
                        cnt_d    = '0;
`endif
                    end
                end
                RUN: begin
                    if (mult_q <= MUL_W'(1)) begin
                        state_d = DONE;
                    end else begin
`ifdef TOP_FAST_MUL_EN
                        result_d = result_q * {{MUL_W{1'b0}}, mult_q};
                        mult_d   = mult_q - MUL_W'(1);
                        if (mult_q == MUL_W'(2)) state_d = DONE;
`else
                        // Load cycle snapshots the operands; the final add lands directly in result
                        if (cnt_q == '0) begin
                            a_d   = result_q;
                            b_d   = mult_q;
                            acc_d = '0;
                            cnt_d = CNT_W'(1);
                        end else begin
                            acc_d = sum;
                            a_d   = a_q << 1;
                            b_d   = b_q >> 1;
                            if (cnt_q == CNT_W'(MUL_W)) begin
                                result_d = sum;
                                mult_d   = mult_q - MUL_W'(1);
                                cnt_d    = '0;
                                if (mult_q == MUL_W'(2)) state_d = DONE;
                            end else begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                        end
`endif
                    end
                end
                DONE: ;
                default: state_d = IDLE;
            endcase
        end
    end

    // Register read mux; write-only and undefined offsets read 0
    always_comb begin
        rdata_o = '0;
        unique case (idx_i)
            REG_OPDONE:   rdata_o = {{(MUL_W-2){1'b0}}, busy, done};
            REG_INTR_EN:  rdata_o = {{(MUL_W-1){1'b0}}, intr_en_q};
            REG_OPERAND:  rdata_o = operand_q;
            REG_RESULT_H: rdata_o = result_q[RES_W-1:MUL_W];
            REG_RESULT_L: rdata_o = result_q[MUL_W-1:0];
            default:      rdata_o = '0;
        endcase
    end

endmodule

// File: rtl/top_soc.sv
// Single-master bus: address decode, 256x64 data memory and factorial accelerator.
// Config macro TOP_FAST_MUL_EN selects the accelerator's single-cycle multiply.
module top_soc
    import top_soc_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 256,
    parameter int unsigned MUL_W     = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        m_req,
    input  logic        m_wr,
    input  logic [15:0] m_addr,
    input  logic [63:0] m_dout,
    output logic        m_grant,
    output logic [63:0] m_din,
    output logic        interrupt
);

    logic [63:0] mem_q [MEM_WORDS];
    logic        mem_sel, reg_sel;
    logic        reg_wr;
    logic [63:0] reg_rdata;
    logic        unused_addr_lo;

    assign mem_sel        = (m_addr[15:11] == MEM_BASE[15:11]);
    assign reg_sel        = (m_addr[15:8] == REG_BASE[15:8]);
    assign reg_wr         = reset_n && m_req && m_wr && reg_sel;
    assign m_grant        = reset_n & m_req;
    assign unused_addr_lo = ^m_addr[2:0];

    // Data memory write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (reset_n && m_req && m_wr && mem_sel) mem_q[m_addr[10:3]] <= m_dout;
    end

    // Combinational read return; zero outside reads, in reset or when unmapped
    always_comb begin
        m_din = '0;
        if (reset_n && m_req && !m_wr) begin
            if (mem_sel)      m_din = mem_q[m_addr[10:3]];
            else if (reg_sel) m_din = reg_rdata;
        end
    end

    fact_core #(
        .MUL_W (MUL_W)
    ) u_fact_core (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .wr_i    (reg_wr),
        .idx_i   (m_addr[7:3]),
        .wdata_i (m_dout),
        .rdata_o (reg_rdata),
        .irq_o   (interrupt)
    );

endmodule

// File: tb/tb_top_soc.sv
// Directed scoreboard bench for top_soc.
module tb_top_soc;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        m_req;
    logic        m_wr;
    logic [15:0] m_addr;
    logic [63:0] m_dout;
    logic        m_grant;
    logic [63:0] m_din;
    logic        interrupt;

    int          n_asserts = 0;
    int          n_fail    = 0;
    logic [63:0] exp_q [$];
    string       tag_q [$];

    always #5 clk = ~clk;

    top_soc dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .m_req     (m_req),
        .m_wr      (m_wr),
        .m_addr    (m_addr),
        .m_dout    (m_dout),
        .m_grant   (m_grant),
        .m_din     (m_din),
        .interrupt (interrupt)
    );

    task automatic push_exp(input logic [63:0] e, input string t);
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    task automatic check(input logic [63:0] obs);
        logic [63:0] e;
        string       t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_asserts++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", t, obs, e);
        end
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [63:0] d);
        @(posedge clk); #1;
        m_req = 1'b1; m_wr = 1'b1; m_addr = a; m_dout = d;
        @(posedge clk); #1;
        m_req = 1'b0; m_wr = 1'b0;
    endtask

    task automatic bus_rd(input logic [15:0] a, input logic [63:0] e, input string t);
        @(posedge clk); #1;
        m_req = 1'b1; m_wr = 1'b0; m_addr = a;
        push_exp(e, t);
        @(negedge clk);
        check(m_din);
    endtask

    task automatic chk_bit(input logic b, input logic e, input string t);
        push_exp({63'b0, e}, t);
        check({63'b0, b});
    endtask

    // Polls opdone.done for at most budget cycles; expiry is a failed comparison
    task automatic wait_done(input int budget, input string t);
        logic seen;
        seen = 1'b0;
        m_req = 1'b1; m_wr = 1'b0; m_addr = 16'h7010;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            if (m_din[0]) seen = 1'b1;
        end
        chk_bit(seen, 1'b1, t);
        m_req = 1'b0;
    endtask

    task automatic clear_pulse();
        bus_wr(16'h7008, 64'd1);
        bus_wr(16'h7008, 64'd0);
    endtask

    initial begin
        reset_n = 1'b0; m_req = 1'b1; m_wr = 1'b0; m_addr = 16'h7010; m_dout = '0;
        #12;
        chk_bit(m_grant, 1'b0, "rst_grant");
        push_exp(64'd0, "rst_din"); check(m_din);
        chk_bit(interrupt, 1'b0, "rst_irq");
        @(negedge clk); reset_n = 1'b1;
        #1;
        chk_bit(m_grant, 1'b1, "grant_follows_req");
        bus_rd(16'h7010, 64'd0, "opdone_after_reset");

        // 10! with interrupt enabled
        bus_wr(16'h7020, 64'd10);
        bus_wr(16'h7018, 64'd1);
        bus_wr(16'h7000, 64'd1);
        wait_done(650, "fact10_done_in_time");
        bus_rd(16'h7028, 64'd0, "fact10_res_h");
        bus_rd(16'h7030, 64'h375F00, "fact10_res_l");
        bus_rd(16'h7010, 64'd1, "fact10_opdone");
        bus_rd(16'h7018, 64'd1, "intr_en_rb");
        bus_rd(16'h7020, 64'd10, "operand_rb");
        chk_bit(interrupt, 1'b1, "fact10_irq");

        // Start while DONE is ignored
        bus_wr(16'h7000, 64'd1);
        bus_rd(16'h7010, 64'd1, "start_in_done_ignored");

        // Clear pulse after done
        clear_pulse();
        bus_rd(16'h7010, 64'd0, "clr_opdone");
        bus_rd(16'h7030, 64'd0, "clr_res_l");
        bus_rd(16'h7028, 64'd0, "clr_res_h");
        chk_bit(interrupt, 1'b0, "clr_irq");

        // Held clear blocks a start (clear wins)
        bus_wr(16'h7008, 64'd1);
        bus_wr(16'h7000, 64'd1);
        bus_rd(16'h7010, 64'd0, "held_clear_blocks_start");
        bus_wr(16'h7008, 64'd0);
        bus_rd(16'h7010, 64'd0, "after_clear_release");

        // Operand <= 1 goes straight to DONE with result 1
        bus_wr(16'h7020, 64'd1);
        bus_wr(16'h7000, 64'd1);
        bus_rd(16'h7010, 64'd1, "op1_done");
        bus_rd(16'h7030, 64'd1, "op1_res");
        clear_pulse();
        bus_wr(16'h7020, 64'd0);
        bus_wr(16'h7000, 64'd1);
        bus_rd(16'h7010, 64'd1, "op0_done");
        bus_rd(16'h7030, 64'd1, "op0_res");
        clear_pulse();

        // Operand write and restart attempt during RUN do not disturb the run
        bus_wr(16'h7020, 64'd5);
        bus_wr(16'h7000, 64'd1);
        bus_rd(16'h7010, 64'd2, "op5_busy");
        bus_wr(16'h7020, 64'd3);
        bus_wr(16'h7000, 64'd1);
        wait_done(400, "op5_done_in_time");
        bus_rd(16'h7030, 64'd120, "op5_res_l");
        bus_rd(16'h7020, 64'd3, "op_write_during_run");
        clear_pulse();

        // 616! is a multiple of 2^128
        bus_wr(16'h7020, 64'd616);
        bus_wr(16'h7000, 64'd1);
        wait_done(50000, "fact616_done_in_time");
        bus_rd(16'h7028, 64'd0, "fact616_res_h");
        bus_rd(16'h7030, 64'd0, "fact616_res_l");
        clear_pulse();

        // Memory and unmapped accesses
        bus_wr(16'h0000, 64'h12349876);
        bus_wr(16'h07F8, 64'hFFFFEEEE99993333);
        bus_wr(16'h02B8, 64'hA5A5A5A55A5A5A5A);
        bus_rd(16'h0000, 64'h12349876, "mem_first");
        bus_rd(16'h07F8, 64'hFFFFEEEE99993333, "mem_last");
        @(posedge clk); #1;
        m_req = 1'b1; m_wr = 1'b1; m_addr = 16'h0ABE; m_dout = 64'hDEAD_BEEF_0000_0001;
        push_exp(64'd0, "din_zero_on_write");
        @(negedge clk); check(m_din);
        @(posedge clk); #1;
        m_req = 1'b0; m_wr = 1'b0;
        bus_rd(16'h0ABE, 64'd0, "unmapped_read");
        bus_rd(16'h02B8, 64'hA5A5A5A55A5A5A5A, "unmapped_no_alias");
        bus_rd(16'h0000, 64'h12349876, "mem_first_intact");
        bus_rd(16'h7038, 64'd0, "reg_undefined_offset");
        @(posedge clk); #1;
        m_req = 1'b0; m_wr = 1'b0; m_addr = 16'h0000;
        push_exp(64'd0, "din_zero_no_req");
        @(negedge clk); check(m_din);

        // Asynchronous reset mid-run
        bus_wr(16'h7020, 64'd20);
        bus_wr(16'h7000, 64'd1);
        repeat (100) @(posedge clk);
        bus_rd(16'h7010, 64'd2, "op20_busy");
        @(posedge clk); #2;
        m_req = 1'b1; m_wr = 1'b0; m_addr = 16'h7010;
        reset_n = 1'b0;
        #1;
        chk_bit(m_grant, 1'b0, "async_rst_grant");
        push_exp(64'd0, "async_rst_din"); check(m_din);
        chk_bit(interrupt, 1'b0, "async_rst_irq");
        @(negedge clk); reset_n = 1'b1;
        bus_rd(16'h7010, 64'd0, "post_rst_opdone");
        bus_rd(16'h7030, 64'd0, "post_rst_res_l");
        bus_rd(16'h7020, 64'd0, "post_rst_operand");
        bus_rd(16'h7018, 64'd0, "post_rst_intr_en");
        bus_rd(16'h0000, 64'h12349876, "mem_survives_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
